// File: rtl/systolic_feeder.sv
// Transmit-side staging buffer for the weight-stationary systolic array: loads an NxN matrix
// row by row, then plays it onto the N row lanes in diagonal-skewed order followed by a drain window.
// Optional build macro SYSTOLIC_FEEDER_REPEAT_EN keeps the matrix after a run so start replays it.
module systolic_feeder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N         = 2,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [N*DATA_W-1:0] wr_data,
  input  logic                wr_last,
  input  logic                start,
  output logic [N*DATA_W-1:0] lane_data,
  output logic [N-1:0]        lane_valid,
  output logic                pe_start,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ROW_W  = $clog2(N);
  localparam int unsigned STEP_W = $clog2(2 * N);
  localparam int unsigned DR_W   = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [ROW_W-1:0]  LastRow   = ROW_W'(N - 1);
  localparam logic [STEP_W-1:0] LastStep  = STEP_W'(2 * N - 2);
  localparam logic [DR_W-1:0]   LastDrain = DR_W'(DRAIN_CYC);

`ifdef SYSTOLIC_FEEDER_REPEAT_EN
  localparam logic RepeatEn = 1'b1;
`else
  localparam logic RepeatEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StReady, StFeed, StDrain, StDone} state_e;

  state_e                     state_q;
  logic [N-1:0][N*DATA_W-1:0] mat_q;
  logic [ROW_W-1:0]           row_q;
  logic [STEP_W-1:0]          step_q;
  logic [DR_W-1:0]            drain_q;
  logic                       wr_ready_q;
  logic                       pe_start_q;
  logic                       busy_q;
  logic                       done_q;
  logic [N*DATA_W-1:0]        lane_data_q;
  logic [N-1:0]               lane_valid_q;

  logic                       wr_fire;
  logic                       row_done;
  logic [STEP_W-1:0]          skew_k;
  logic [N*DATA_W-1:0]        skew_data;
  logic [N-1:0]               skew_valid;

  assign wr_fire  = wr_valid && wr_ready_q;
  assign row_done = wr_last || (row_q == LastRow);

  // Lane contents for the step that the next clock edge will present.
  always_comb begin
    skew_k     = (state_q == StFeed) ? step_q + 1'b1 : '0;
    skew_data  = '0;
    skew_valid = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (skew_k == STEP_W'(i + j)) begin
          skew_data[j*DATA_W +: DATA_W] = mat_q[i][j*DATA_W +: DATA_W];
          skew_valid[j]                 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mat_q        <= '0;
      row_q        <= '0;
      step_q       <= '0;
      drain_q      <= '0;
      wr_ready_q   <= 1'b0;
      pe_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StLoad: begin
          wr_ready_q <= 1'b1;
          if (wr_fire) begin
            mat_q[row_q] <= wr_data;
            if (row_done) begin
              state_q    <= StReady;
              wr_ready_q <= RepeatEn;
            end else begin
              state_q <= StLoad;
              row_q   <= row_q + 1'b1;
            end
          end
        end
        StReady: begin
          if (RepeatEn && wr_fire) begin
            // A write here abandons the held matrix and restarts loading at row 0.
            mat_q    <= '0;
            mat_q[0] <= wr_data;
            if (wr_last) begin
              row_q <= '0;
            end else begin
              state_q <= StLoad;
              row_q   <= ROW_W'(1);
            end
          end else if (start) begin
            state_q      <= StFeed;
            step_q       <= '0;
            lane_data_q  <= skew_data;
            lane_valid_q <= skew_valid;
            pe_start_q   <= 1'b1;
            busy_q       <= 1'b1;
            wr_ready_q   <= 1'b0;
          end
        end
        StFeed: begin
          if (step_q == LastStep) begin
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            if (DRAIN_CYC == 0) begin
              state_q    <= StDone;
              pe_start_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= StDrain;
              drain_q <= DR_W'(1);
            end
          end else begin
            step_q       <= step_q + 1'b1;
            lane_data_q  <= skew_data;
            lane_valid_q <= skew_valid;
          end
        end
        StDrain: begin
          if (drain_q == LastDrain) begin
            state_q    <= StDone;
            pe_start_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          busy_q     <= 1'b0;
          row_q      <= '0;
          wr_ready_q <= 1'b1;
          if (RepeatEn) begin
            state_q <= StReady;
          end else begin
            state_q <= StIdle;
            mat_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_ready   = wr_ready_q;
  assign lane_data  = lane_data_q;
  assign lane_valid = lane_valid_q;
  assign pe_start   = pe_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Transmit-side staging block for the weight-stationary systolic array. It accepts an NxN input matrix row by row over a valid/ready write port and stores it in a local buffer. On start it drives the matrix onto the array's N row lanes in diagonally skewed order. It then holds pe_start through a drain window and signals done, so the array's input lanes no longer need a hard-coded per-state feed sequence.

Parameters:
DATA_W, 32, lane/element width in bits
N, 2, array dimension (matrix is NxN, N lanes), N >= 2
DRAIN_CYC, 4, cycles pe_start stays high after the last skewed element, so results can propagate to the array bottom

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
wr_valid  in  1  write row valid
wr_ready  out  1  feeder can accept a row
wr_data  in  N*DATA_W  one matrix row; element j at bits [j*DATA_W +: DATA_W]
wr_last  in  1  final row of the matrix
start  in  1  begin skewed transmission (level, sampled in READY only)
lane_data  out  N*DATA_W  lane j drives array row j input
lane_valid  out  N  per-lane element-valid
pe_start  out  1  enable to all PEs
busy  out  1  high in FEED, DRAIN, DONE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0 (wr_ready 0 during reset, 1 on first cycle after), buffer cleared, state IDLE, row counter 0.
- States: IDLE -> LOAD -> READY -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE/LOAD: wr_ready=1. A row is written on wr_valid&&wr_ready into buffer row r (r = row counter), then r++. The state enters LOAD on the first write.
- Transition to READY occurs on a write with wr_last=1, or on the write of row N-1, whichever comes first. Rows not written are zero-filled. wr_last on row N-1 is normal.
- READY: wr_ready=0, and wr_valid is ignored. start=1 -> FEED next cycle, with step counter k=0.
- start in IDLE/LOAD is ignored; no queuing.
- FEED lasts 2N-1 cycles, k=0..2N-2. All outputs are registered.
- In FEED step k, lane j = A[k-j][j] and lane_valid[j]=1 when 0 <= k-j < N. Otherwise lane j = 0 and lane_valid[j]=0.
- pe_start goes to 1 in the first FEED cycle.
- DRAIN: lanes = 0, lane_valid = 0, pe_start held 1 for exactly DRAIN_CYC cycles.
- DONE (1 cycle): done=1, pe_start=0, buffer cleared, row counter 0. The next state is IDLE.
- Latency: first skewed element is on lane_data the cycle after start is sampled. done asserts 2N-1+DRAIN_CYC+1 cycles after that sample.
- start held high through FEED/DRAIN/DONE has no effect. A new run requires a new load.
- Reset mid-FEED/DRAIN: outputs return to 0 immediately (async), the buffer is discarded, and no done is issued.
- The block does no arithmetic. Elements pass bit-exact.

Optional Feature:
SYSTOLIC_FEEDER_REPEAT_EN
- Defined: DONE does not clear the buffer. It returns to READY instead of IDLE, so start replays the same matrix. A write attempt in READY (wr_valid=1) clears the buffer and returns to LOAD that cycle, with the row accepted as row 0. In this mode wr_ready=1 in READY.
- Undefined: behaviour exactly as above (clear on DONE, READY ignores writes).

Test Plan:
- N=2, DRAIN_CYC=4: write rows [1,2], [3,4] (wr_last on row 1), then start -> lane0 = 1,3,0 and lane1 = 0,2,4 on consecutive cycles. lane_valid = {0,1},{1,1},{1,0} (bit1,bit0). pe_start high for 7 cycles, then done pulses once.
- Early last: write a single row [5,6] with wr_last=1, then start -> lane0 = 5,0,0 and lane1 = 0,6,0; row 1 is zero-filled.
- Handshake: in READY drive wr_valid=1 with [9,9] -> wr_ready=0 and the buffer is unchanged. A subsequent feed still emits 1,3 / 2,4.
- start in IDLE and mid-LOAD -> no lane activity, pe_start stays 0. After load completes, start works normally.
- Assert reset during FEED step 1 -> lanes, pe_start and busy go to 0 immediately and done never pulses. After a reload of [7,8],[1,1] and start, the feed is correct.
- With SYSTOLIC_FEEDER_REPEAT_EN: load [1,2],[3,4] and run twice -> identical lane sequences. A write in READY restarts loading from row 0.
